// File: rtl/apb3_pkg.sv
// Shared types and helpers for the APB3 master/slave link.
// Holds the default bus widths, the master state encoding and the slave address check.
package apb3_pkg;

    localparam int unsigned APB_ADDR_W    = 32;
    localparam int unsigned APB_DATA_W    = 32;
    localparam int unsigned APB_MEM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Out of range (beyond depth words) or not word aligned.
    function automatic logic apb_addr_err(input logic [63:0] addr, input int unsigned depth);
        return (addr >= (64'(depth) << 2)) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/apb3_slave_mem.sv
// APB3 register-file slave with a per-transfer wait-state counter.
// PREADY, PSLVERR and PRDATA are combinational from the access phase and the counter.
module apb3_slave_mem
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_W    = APB_ADDR_W,
    parameter int unsigned DATA_W    = APB_DATA_W,
    parameter int unsigned MEM_DEPTH = APB_MEM_DEPTH
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [3:0]        slv_wait_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [3:0]        wait_q;
    logic              setup_phase;
    logic              access_phase;
    logic              addr_err;
    logic [IDX_W-1:0]  idx;

    assign setup_phase  = psel_i & ~penable_i;
    assign access_phase = psel_i & penable_i;
    assign addr_err     = apb_addr_err(64'(paddr_i), MEM_DEPTH);
    assign idx          = paddr_i[IDX_W+1:2];

    always_comb begin
        pready_o  = 1'b1;
        if (access_phase) begin
            pready_o = (wait_q == 4'd0);
        end
        pslverr_o = access_phase & pready_o & addr_err;
        prdata_o  = (access_phase & ~pwrite_i & ~addr_err) ? mem_q[idx] : '0;
    end

    // The wait count is captured in SETUP so later slv_wait changes cannot stretch this transfer.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            wait_q <= 4'd0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (setup_phase) begin
                wait_q <= slv_wait_i;
            end else if (access_phase && (wait_q != 4'd0)) begin
                wait_q <= wait_q - 4'd1;
            end
            if (access_phase && pready_o && pwrite_i && !addr_err) begin
                mem_q[idx] <= pwdata_i;
            end
        end
    end

endmodule

// File: rtl/apb3_ms_link.sv
// APB3 master driven by a command/response port, wired to a register-file slave.
// state  | meaning
// IDLE   | ready for a command; bus address/data hold their last value
// SETUP  | PSELx=1, PENABLE=0; slave captures its wait count
// ACCESS | PSELx=1, PENABLE=1; leave when PREADY=1
module apb3_ms_link
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_W    = APB_ADDR_W,
    parameter int unsigned DATA_W    = APB_DATA_W,
    parameter int unsigned MEM_DEPTH = APB_MEM_DEPTH
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        slv_wait,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    apb_state_e        state_q, state_d;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              accept;
    logic              complete;

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= complete;
            if (accept) begin
                pwrite_q <= cmd_write;
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_wdata;
            end
            if (complete) begin
                rsp_rdata_q <= PRDATA;
                rsp_err_q   <= PSLVERR;
            end
        end
    end

    assign PSELx     = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    apb3_slave_mem #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_slave (
        .pclk_i     (PCLK),
        .presetn_i  (PRESETn),
        .psel_i     (PSELx),
        .penable_i  (PENABLE),
        .pwrite_i   (PWRITE),
        .paddr_i    (PADDR),
        .pwdata_i   (PWDATA),
        .slv_wait_i (slv_wait),
        .prdata_o   (PRDATA),
        .pready_o   (PREADY),
        .pslverr_o  (PSLVERR)
    );

endmodule

// File: tb/tb_apb3_ms_link.sv
// Bench for apb3_ms_link: directed scenarios plus randomized traffic against a word-array model.
module tb_apb3_ms_link;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  slv_wait;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_accept = 0;

    logic [31:0] model [16];
    bit psel_tr [64];
    bit pen_tr  [64];
    bit prdy_tr [64];
    bit serr_tr [64];
    bit crdy_tr [64];

    apb3_ms_link dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .slv_wait  (slv_wait),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic bit model_err(input logic [31:0] a);
        return (a >= 32'd64) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (model_err(a)) return 32'h0;
        if (wr) begin
            model[a[5:2]] = d;
            return 32'h0;
        end
        return model[a[5:2]];
    endfunction

    task automatic record(input int lat);
        if (lat < 64) begin
            psel_tr[lat] = PSELx;
            pen_tr[lat]  = PENABLE;
            prdy_tr[lat] = PREADY;
            serr_tr[lat] = PSLVERR;
            crdy_tr[lat] = cmd_ready;
        end
    endtask

    // Called at a negedge while the master is idle; returns at the negedge of the response cycle.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input bit scramble, output logic [31:0] rd, output bit er, output int lat);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; slv_wait = w;
        last_accept = cyc;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        lat = 1;
        record(lat);
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge PCLK);
            lat++;
            if (scramble && lat >= 2) slv_wait = 4'($urandom);
            record(lat);
        end
        checks++;
        if (lat >= 40) begin
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles for addr %h", lat, a);
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({PSELx, PENABLE, PWRITE, PSLVERR, rsp_valid, rsp_err} !== 6'b0) begin
            errors++;
            $display("FAIL %s_ctrl: sel/en/wr/slverr/rv/rerr=%b expected 000000", tag,
                     {PSELx, PENABLE, PWRITE, PSLVERR, rsp_valid, rsp_err});
        end
        checks++;
        if ({PADDR, PWDATA, PRDATA, rsp_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL %s_data: paddr=%h pwdata=%h prdata=%h rsp_rdata=%h expected all 0",
                     tag, PADDR, PWDATA, PRDATA, rsp_rdata);
        end
        checks++;
        if (PREADY !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: pready=%b cmd_ready=%b expected 1 1", tag, PREADY, cmd_ready);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; slv_wait = '0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (3) @(negedge PCLK);
        check_reset_outputs("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_single_write();
        logic [31:0] rd; bit er; int lat;
        xfer(1'b1, 32'h4, 32'hDEAD_BEEF, 4'd0, 1'b0, rd, er, lat);
        void'(model_xfer(1'b1, 32'h4, 32'hDEAD_BEEF));
        checks++;
        if (lat != 3 || er !== 1'b0) begin
            errors++;
            $display("FAIL single_write_rsp: latency=%0d err=%b expected 3 0", lat, er);
        end
        checks++;
        if ({psel_tr[1], psel_tr[2], pen_tr[1], pen_tr[2], psel_tr[3]} !== 5'b11010) begin
            errors++;
            $display("FAIL single_write_bus: psel1/psel2/pen1/pen2/psel3=%b expected 11010",
                     {psel_tr[1], psel_tr[2], pen_tr[1], pen_tr[2], psel_tr[3]});
        end
    endtask

    task automatic test_single_read();
        logic [31:0] rd; bit er; int lat;
        xfer(1'b0, 32'h4, 32'h0, 4'd0, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat != 3 || er !== 1'b0) begin
            errors++;
            $display("FAIL single_read: rdata=%h lat=%0d err=%b expected deadbeef 3 0", rd, lat, er);
        end
        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse_width: rsp_valid=%b one cycle later, expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; bit er; int lat; int prev;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] a;
                logic [31:0] exp;
                a = 32'(i * 4);
                prev = last_accept;
                xfer(pass == 0, a, a * 3, 4'd0, 1'b0, rd, er, lat);
                exp = model_xfer(pass == 0, a, a * 3);
                checks++;
                if (rd !== exp || er !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_data[%0d/%0d]: rdata=%h err=%b expected %h 0", pass, i, rd, er, exp);
                end
                if (i > 0 || pass > 0) begin
                    checks++;
                    if (last_accept - prev != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d/%0d]: %0d cycles expected 3", pass, i, last_accept - prev);
                    end
                end
            end
        end
    endtask

    task automatic test_extended();
        logic [31:0] rd; bit er; int lat;
        xfer(1'b1, 32'h8, 32'h1234_5678, 4'd3, 1'b0, rd, er, lat);
        void'(model_xfer(1'b1, 32'h8, 32'h1234_5678));
        checks++;
        if (lat != 6 || {prdy_tr[2], prdy_tr[3], prdy_tr[4], prdy_tr[5]} !== 4'b0001
            || {pen_tr[2], pen_tr[5], crdy_tr[4]} !== 3'b110) begin
            errors++;
            $display("FAIL ext_write_timing: lat=%0d pready2..5=%b pen2/pen5/ready4=%b expected 6 0001 110",
                     lat, {prdy_tr[2], prdy_tr[3], prdy_tr[4], prdy_tr[5]}, {pen_tr[2], pen_tr[5], crdy_tr[4]});
        end
        xfer(1'b0, 32'h8, 32'h0, 4'd3, 1'b0, rd, er, lat);
        checks++;
        if (rd !== model[2] || lat != 6) begin
            errors++;
            $display("FAIL ext_read: rdata=%h lat=%0d expected %h 6", rd, lat, model[2]);
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; bit er; int lat;
        logic [31:0] bad [2];
        bad[0] = 32'h40; bad[1] = 32'h2;
        for (int i = 0; i < 2; i++) begin
            xfer(1'b1, bad[i], 32'hFFFF_FFFF, 4'd0, 1'b0, rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0 || serr_tr[2] !== 1'b1 || serr_tr[1] !== 1'b0) begin
                errors++;
                $display("FAIL err_write[%h]: err=%b rdata=%h pslverr1/2=%b%b expected 1 0 01",
                         bad[i], er, rd, serr_tr[1], serr_tr[2]);
            end
        end
        xfer(1'b0, 32'h0, 32'h0, 4'd0, 1'b0, rd, er, lat);
        checks++;
        if (rd !== model[0] || er !== 1'b0) begin
            errors++;
            $display("FAIL err_mem_intact: rdata=%h err=%b expected %h 0", rd, er, model[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; bit er; int lat; bit seen;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hCAFE_F00D; slv_wait = 4'd5;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_rsp: rsp_valid seen=1 expected 0");
        end
        xfer(1'b0, 32'h10, 32'h0, 4'd0, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_word: rdata=%h expected 0", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; bit er; int lat;
        for (int n = 0; n < 60; n++) begin
            bit wr;
            logic [31:0] a, d, exp;
            logic [3:0] w;
            wr = 1'($urandom);
            a = 32'($urandom_range(0, 19) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            d = $urandom;
            w = 4'($urandom_range(0, 6));
            xfer(wr, a, d, w, 1'b1, rd, er, lat);
            exp = model_xfer(wr, a, d);
            checks++;
            if (rd !== exp || er !== model_err(a) || lat != 3 + int'(w) || PADDR !== a) begin
                errors++;
                $display("FAIL rand[%0d] wr=%b addr=%h: rdata=%h err=%b lat=%0d paddr=%h expected %h %b %0d %h",
                         n, wr, a, rd, er, lat, PADDR, exp, model_err(a), 3 + int'(w), a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_extended();
        test_error();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
